// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, TX launch FSM encoding and the
// baud constants common to sender, receiver and the TX FIFO front end.
package uart_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned BAUD       = 115_200;
    localparam int unsigned OVERSAMPLE = 16;
    // Rounded to nearest so the bit period error stays below half a clock.
    localparam int unsigned BAUD_DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned RX_DIV     = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitDone = 2'd2
    } txState_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with registered count/full/empty.
// Storage contents are deliberately left out of reset.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
        $error("uart_sync_fifo: DEPTH must be a power of two in 2..256");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtrQ, rdPtrQ;
    logic [AW:0]       countQ, countD;
    logic              fullQ, emptyQ;
    logic              wrAcc, rdAcc;

    // Acceptance uses the registered flags, so a write while full is dropped
    // even when a pop frees a slot on the same edge.
    assign wrAcc = wr_en && !fullQ;
    assign rdAcc = rd_en && !emptyQ;

    always_comb begin
        countD = countQ;
        if (wrAcc && !rdAcc) begin
            countD = countQ + 1'b1;
        end else if (!wrAcc && rdAcc) begin
            countD = countQ - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
            fullQ  <= 1'b0;
            emptyQ <= 1'b1;
        end else begin
            if (wrAcc) begin
                wrPtrQ <= wrPtrQ + 1'b1;
            end
            if (rdAcc) begin
                rdPtrQ <= rdPtrQ + 1'b1;
            end
            countQ <= countD;
            fullQ  <= (countD == FullCnt);
            emptyQ <= (countD == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wrAcc) begin
            mem[wrPtrQ] <= wr_data;
        end
    end

    assign rd_data = mem[rdPtrQ];
    assign full    = fullQ;
    assign empty   = emptyQ;
    assign count   = countQ;

    assert property (@(posedge clk) disable iff (!rst_n) !(fullQ && emptyQ));
    assert property (@(posedge clk) disable iff (!rst_n) countQ <= FullCnt);

endmodule

// File: rtl/uart_tx_fifo.sv
// TX FIFO front end: buffers frame bytes and launches them to the UART sender.
// Define UART_TX_FIFO_OVF_EN to add the sticky ovf output for dropped writes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     txStart,
    output logic [DATA_W-1:0]        in_data,
    input  logic                     txBusy,
    input  logic                     txDone
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                     ovf
`endif
);

    txState_e          stateQ, stateD;
    logic              pop;
    logic [DATA_W-1:0] fifoRdData;
    logic [DATA_W-1:0] inDataQ;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifoRdData),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // en only gates new launches; a frame already handed over runs to txDone.
    always_comb begin
        stateD = stateQ;
        pop    = 1'b0;
        case (stateQ)
            StIdle: begin
                if (en && !empty && !txBusy) begin
                    pop    = 1'b1;
                    stateD = StLaunch;
                end
            end
            StLaunch: begin
                stateD = StWaitDone;
            end
            StWaitDone: begin
                if (txDone) begin
                    stateD = StIdle;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ  <= StIdle;
            inDataQ <= '0;
        end else begin
            stateQ <= stateD;
            if (pop) begin
                inDataQ <= fifoRdData;
            end
        end
    end

    assign txStart = (stateQ == StLaunch);
    assign in_data = inDataQ;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovfQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovfQ <= 1'b0;
        end else if (wr_en && full) begin
            ovfQ <= 1'b1;
        end
    end

    assign ovf = ovfQ;
`endif

    assert property (@(posedge clk) disable iff (!rst_n) txStart |=> !txStart);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a behavioural sender/receiver and a queue model.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n, en, wr_en;
    logic [7:0]    wr_data;
    logic          full, empty;
    logic [CW-1:0] count;
    logic          txStart;
    logic [7:0]    in_data;
    logic          txBusy, txDone;
    logic          busyForce;
`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf;
    logic          ovfM;
`endif

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .txStart (txStart),
        .in_data (in_data),
        .txBusy  (txBusy),
        .txDone  (txDone)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    // Sender + receiver: frame lasts frameLen cycles, receiver logs the byte.
    logic       sndBusy;
    int         sndCnt;
    logic [7:0] sndByte;
    int         frameLen = 2;
    logic [7:0] rxQ[$];
    int         rxDoneCnt = 0;

    assign txBusy = sndBusy | busyForce;

    initial begin
        sndBusy = 1'b0;
        txDone  = 1'b0;
        sndCnt  = 0;
        sndByte = '0;
        forever begin
            @(posedge clk);
            #2;
            txDone = 1'b0;
            if (!rst_n) begin
                sndBusy = 1'b0;
            end else if (sndBusy) begin
                if (sndCnt <= 1) begin
                    sndBusy = 1'b0;
                    txDone  = 1'b1;
                    rxQ.push_back(sndByte);
                    rxDoneCnt++;
                end else begin
                    sndCnt--;
                end
            end else if (txStart) begin
                sndBusy = 1'b1;
                sndCnt  = frameLen;
                sndByte = in_data;
            end
        end
    end

    // Reference model: FIFO as a queue, launcher as "idle / launching / waiting".
    logic [7:0] mq[$];
    logic [7:0] launchLog[$];
    int         stage = 0;
    int         launches = 0;

    initial begin : monitor
        logic       rP, wP, eP, bP, tdP;
        logic [7:0] dP, expB, curByte;
        logic       fullB, emptyB, launchOk;
        curByte = '0;
`ifdef UART_TX_FIFO_OVF_EN
        ovfM = 1'b0;
`endif
        forever begin
            @(posedge clk);
            rP = rst_n; wP = wr_en; dP = wr_data; eP = en; bP = txBusy; tdP = txDone;
            #1;
            if (!rP) begin
                mq.delete();
                stage   = 0;
                curByte = '0;
`ifdef UART_TX_FIFO_OVF_EN
                ovfM = 1'b0;
`endif
                checks++;
                if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || txStart !== 1'b0
                    || in_data !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_state: count=%0d empty=%b full=%b txStart=%b in_data=%h, want 0 1 0 0 00",
                             count, empty, full, txStart, in_data);
                end
            end else begin
                fullB    = (mq.size() == DEPTH);
                emptyB   = (mq.size() == 0);
                launchOk = (stage == 0) && eP && !emptyB && !bP;
                checks++;
                if (txStart !== launchOk) begin
                    errors++;
                    $display("FAIL launch_decision @%0t: txStart=%b, want %b", $time, txStart, launchOk);
                end
                if (launchOk) begin
                    expB    = mq.pop_front();
                    curByte = expB;
                    launchLog.push_back(expB);
                    launches++;
                    checks++;
                    if (in_data !== expB) begin
                        errors++;
                        $display("FAIL launch_data @%0t: in_data=%h, want %h", $time, in_data, expB);
                    end
                end else if (stage != 0) begin
                    checks++;
                    if (in_data !== curByte) begin
                        errors++;
                        $display("FAIL data_hold @%0t: in_data=%h, want %h", $time, in_data, curByte);
                    end
                end
                if (stage == 1)                 stage = 2;
                else if (stage == 2 && tdP)     stage = 0;
                else if (stage == 0 && launchOk) stage = 1;
                if (wP && !fullB) mq.push_back(dP);
`ifdef UART_TX_FIFO_OVF_EN
                if (wP && fullB) ovfM = 1'b1;
                checks++;
                if (ovf !== ovfM) begin
                    errors++;
                    $display("FAIL ovf_flag @%0t: ovf=%b, want %b", $time, ovf, ovfM);
                end
`endif
                checks++;
                if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH)
                    || empty !== (mq.size() == 0)) begin
                    errors++;
                    $display("FAIL occupancy @%0t: count=%0d full=%b empty=%b, want count=%0d",
                             $time, count, full, empty, mq.size());
                end
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((mq.size() != 0 || stage != 0 || sndBusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: %0d entries still queued after %0d cycles, want 0",
                     tag, mq.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_data = '0; busyForce = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (count !== '0)    begin errors++; $display("FAIL rst_count: %0d, want 0", count); end
        checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL rst_empty: %b, want 1", empty); end
        checks++; if (full !== 1'b0)   begin errors++; $display("FAIL rst_full: %b, want 0", full); end
        checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL rst_txStart: %b, want 0", txStart); end
        checks++; if (in_data !== 8'h00) begin errors++; $display("FAIL rst_in_data: %h, want 00", in_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3] = '{8'hA5, 8'h3C, 8'h7F};
        int l0 = launches;
        int r0 = rxDoneCnt;
        rxQ.delete();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_drain("b2b", 200);
        checks++;
        if (rxQ.size() != 3) begin errors++; $display("FAIL b2b_rx_count: %0d, want 3", rxQ.size()); end
        for (int i = 0; i < 3 && i < rxQ.size(); i++) begin
            checks++;
            if (rxQ[i] !== exp[i]) begin
                errors++; $display("FAIL b2b_rx_data[%0d]: %h, want %h", i, rxQ[i], exp[i]);
            end
        end
        checks++;
        if (launches - l0 != 3) begin errors++; $display("FAIL b2b_txStart_pulses: %0d, want 3", launches - l0); end
        checks++;
        if (rxDoneCnt - r0 != 3) begin errors++; $display("FAIL b2b_rxDone_pulses: %0d, want 3", rxDoneCnt - r0); end
    endtask

    task automatic test_overflow();
        rxQ.delete();
        en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = (i == 16) ? 8'hFF : 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: %b, want 1", full); end
        checks++; if (count !== CW'(16)) begin errors++; $display("FAIL ovf_count: %0d, want 16", count); end
`ifdef UART_TX_FIFO_OVF_EN
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: %b, want 1", ovf); end
`endif
        en = 1'b1;
        wait_drain("ovf", 1000);
        checks++;
        if (rxQ.size() != 16) begin errors++; $display("FAIL ovf_rx_count: %0d, want 16", rxQ.size()); end
        for (int i = 0; i < 16 && i < rxQ.size(); i++) begin
            checks++;
            if (rxQ[i] !== 8'(i)) begin
                errors++; $display("FAIL ovf_rx_data[%0d]: %h, want %h", i, rxQ[i], 8'(i));
            end
        end
    endtask

    task automatic test_full_pop_write();
        rxQ.delete();
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            @(negedge clk);
        end
        en = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== CW'(15)) begin errors++; $display("FAIL popwr_count: %0d, want 15", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL popwr_full: %b, want 0", full); end
        wait_drain("popwr", 1000);
        checks++;
        if (rxQ.size() != 16) begin errors++; $display("FAIL popwr_rx_count: %0d, want 16", rxQ.size()); end
        for (int i = 0; i < 16 && i < rxQ.size(); i++) begin
            checks++;
            if (rxQ[i] !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL popwr_rx_data[%0d]: %h, want %h", i, rxQ[i], 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        frameLen = 20;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        while (!(stage == 2 && mq.size() == 4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL midrst_setup: stage=%0d queued=%0d, want 2 and 4", stage, mq.size()); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (count !== '0) begin errors++; $display("FAIL midrst_count: %0d, want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: %b, want 1", empty); end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checks++;
            if (txStart !== 1'b0) begin errors++; $display("FAIL midrst_txStart cycle %0d: %b, want 0", i, txStart); end
        end
        frameLen = 2;
    endtask

    task automatic test_busy_hold();
        rxQ.delete();
        busyForce = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'h90 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (txStart !== 1'b0) begin errors++; $display("FAIL busy_hold cycle %0d: txStart=%b, want 0", i, txStart); end
        end
        busyForce = 1'b0;
        @(negedge clk);
        checks++;
        if (txStart !== 1'b1) begin errors++; $display("FAIL busy_release: txStart=%b, want 1", txStart); end
        checks++;
        if (in_data !== 8'h90) begin errors++; $display("FAIL busy_release_data: %h, want 90", in_data); end
        wait_drain("busy", 200);
        checks++;
        if (rxQ.size() != 2) begin errors++; $display("FAIL busy_rx_count: %0d, want 2", rxQ.size()); end
    endtask

    task automatic test_wrap();
        rxQ.delete();
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        en = 1'b1;
        wait_drain("wrap8", 400);
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (count !== CW'(12)) begin errors++; $display("FAIL wrap_count: %0d, want 12", count); end
        en = 1'b1;
        wait_drain("wrap12", 600);
        checks++;
        if (rxQ.size() != 20) begin errors++; $display("FAIL wrap_rx_count: %0d, want 20", rxQ.size()); end
        for (int i = 0; i < 20 && i < rxQ.size(); i++) begin
            logic [7:0] e;
            e = (i < 8) ? 8'h80 + 8'(i) : 8'hC0 + 8'(i - 8);
            checks++;
            if (rxQ[i] !== e) begin errors++; $display("FAIL wrap_rx_data[%0d]: %h, want %h", i, rxQ[i], e); end
        end
    endtask

    task automatic test_random();
        rxQ.delete();
        launchLog.delete();
        frameLen = int'($urandom_range(1, 5));
        for (int i = 0; i < 800; i++) begin
            wr_en     = ($urandom_range(0, 99) < 60);
            wr_data   = 8'($urandom);
            en        = ($urandom_range(0, 99) < 80);
            busyForce = ($urandom_range(0, 99) < 10);
            if (i % 200 == 199) frameLen = int'($urandom_range(1, 5));
            @(negedge clk);
        end
        wr_en = 1'b0; busyForce = 1'b0; en = 1'b1;
        wait_drain("rand", 2000);
        checks++;
        if (rxQ.size() != launchLog.size()) begin
            errors++; $display("FAIL rand_rx_count: %0d, want %0d", rxQ.size(), launchLog.size());
        end
        for (int i = 0; i < rxQ.size() && i < launchLog.size(); i++) begin
            checks++;
            if (rxQ[i] !== launchLog[i]) begin
                errors++; $display("FAIL rand_rx_data[%0d]: %h, want %h", i, rxQ[i], launchLog[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_data = '0; busyForce = 1'b0;
        test_reset();
        test_back_to_back();
        test_overflow();
        test_reset();
        test_full_pop_write();
        test_reset_midframe();
        test_busy_hold();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
